// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 default timing for the VGA raster timing generator.
package vga_pkg;

    localparam int VGA_CW   = 10;
    localparam int VGA_H_AV = 640;
    localparam int VGA_H_FP = 16;
    localparam int VGA_H_SP = 96;
    localparam int VGA_H_BP = 48;
    localparam int VGA_V_AV = 480;
    localparam int VGA_V_FP = 10;
    localparam int VGA_V_SP = 2;
    localparam int VGA_V_BP = 33;

    typedef struct packed {
        logic       hSync;
        logic       vSync;
        logic       valid;
        logic [2:0] rgb;
    } vga_ctl_t;

    function automatic int vga_total(input int av, input int fp, input int sp, input int bp);
        return av + fp + sp + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable qualified shift register for video control bits; DEPTH=0 is a plain wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int  DEPTH = 0,
    parameter type T     = vga_ctl_t,
    parameter T    INIT  = '0
) (
    input  logic pixClk,
    input  logic reset,
    input  logic ce,
    input  T     din,
    output T     dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = &{1'b0, pixClk, reset, ce};
            assign dout = din;
        end else begin : g_shift
            T stage_reg [DEPTH];
            genvar gi;
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge pixClk or posedge reset) begin
                        if (reset) begin
                            stage_reg[gi] <= INIT;
                        end else if (ce) begin
                            stage_reg[gi] <= din;
                        end
                    end
                end else begin : g_tail
                    always_ff @(posedge pixClk or posedge reset) begin
                        if (reset) begin
                            stage_reg[gi] <= INIT;
                        end else if (ce) begin
                            stage_reg[gi] <= stage_reg[gi-1];
                        end
                    end
                end
            end
            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with aligned sync/valid delay line.
// Optional colour-bar test pattern is built when VGA_TIMING_PATTERN_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW         = VGA_CW,
    parameter int H_AV       = VGA_H_AV,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SP       = VGA_H_SP,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_AV       = VGA_V_AV,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SP       = VGA_V_SP,
    parameter int V_BP       = VGA_V_BP,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int FC_W       = 8
) (
    input  logic            pixClk,
    input  logic            reset,
    input  logic            ce,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            hSync,
    output logic            vSync,
    output logic            valid,
    output logic            lineStart,
    output logic            frameStart,
    output logic [FC_W-1:0] frameCount,
    output logic            hSyncD,
    output logic            vSyncD,
    output logic            validD,
    output logic            patR,
    output logic            patG,
    output logic            patB
);

    localparam int H_TOTAL = vga_total(H_AV, H_FP, H_SP, H_BP);
    localparam int V_TOTAL = vga_total(V_AV, V_FP, V_SP, V_BP);

    // A non-zero back porch keeps the sync end strictly below the total, so every
    // decode constant below fits in CW bits.
    generate
        if (longint'(H_TOTAL) > (longint'(1) << CW) || longint'(V_TOTAL) > (longint'(1) << CW)
            || H_BP < 1 || V_BP < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_cfg
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_AV);
    localparam logic [CW-1:0] V_ACT  = CW'(V_AV);
    localparam logic [CW-1:0] HS_BEG = CW'(H_AV + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_AV + H_FP + H_SP);
    localparam logic [CW-1:0] VS_BEG = CW'(V_AV + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_AV + V_FP + V_SP);

    localparam vga_ctl_t CTL_IDLE = '{hSync: ~H_POL, vSync: ~V_POL, valid: 1'b0, rgb: 3'b000};

    logic [CW-1:0]   x_reg, x_next;
    logic [CW-1:0]   y_reg, y_next;
    logic [FC_W-1:0] fc_reg, fc_next;

    always_comb begin
        x_next  = x_reg;
        y_next  = y_reg;
        fc_next = fc_reg;
        if (ce) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                if (y_reg == V_LAST) begin
                    y_next  = '0;
                    fc_next = fc_reg + 1'b1;
                end else begin
                    y_next = y_reg + 1'b1;
                end
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Reset parks on the last pixel of the frame so the first enabled edge lands on (0,0).
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            x_reg  <= H_LAST;
            y_reg  <= V_LAST;
            fc_reg <= '1;
        end else begin
            x_reg  <= x_next;
            y_reg  <= y_next;
            fc_reg <= fc_next;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign frameCount = fc_reg;

    assign hSync      = ((x_reg >= HS_BEG) && (x_reg < HS_END)) ? H_POL : ~H_POL;
    assign vSync      = ((y_reg >= VS_BEG) && (y_reg < VS_END)) ? V_POL : ~V_POL;
    assign valid      = (x_reg < H_ACT) && (y_reg < V_ACT);
    assign lineStart  = (x_reg == '0);
    assign frameStart = (x_reg == '0) && (y_reg == '0);

    logic [2:0] rgb0;

`ifdef VGA_TIMING_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_AV / 8);
    logic [CW-1:0] bar_idx;
    logic          unused_bar;
    assign bar_idx    = x_reg / BAR_W;
    assign unused_bar = ^bar_idx[CW-1:3];
    // White bar first, black bar last; blanked outside the active area.
    assign rgb0       = valid ? (3'b111 - bar_idx[2:0]) : 3'b000;
`else
    assign rgb0 = 3'b000;
`endif

    vga_ctl_t ctl0, ctl_d;
    assign ctl0 = '{hSync: hSync, vSync: vSync, valid: valid, rgb: rgb0};

    vga_delay_line #(
        .DEPTH (PIPE_DELAY),
        .T     (vga_ctl_t),
        .INIT  (CTL_IDLE)
    ) u_delay (
        .pixClk (pixClk),
        .reset  (reset),
        .ce     (ce),
        .din    (ctl0),
        .dout   (ctl_d)
    );

    assign hSyncD = ctl_d.hSync;
    assign vSyncD = ctl_d.vSync;
    assign validD = ctl_d.valid;
    assign patR   = ctl_d.rgb[2];
    assign patG   = ctl_d.rgb[1];
    assign patB   = ctl_d.rgb[0];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It replaces the fixed 640x480 driver with configurable resolution, porches, sync polarity and clock-enable. It provides a configurable delay line that aligns syncs and valid with downstream video pipelines, plus line/frame strobes and a frame counter. It sits between the pixel PLL and the video generators.

Parameters:
- CW, 10, counter width for x/y.
- H_AV, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SP, 96, horizontal sync pulse in pixels.
- H_BP, 48, horizontal back porch in pixels; must be >= 1.
- V_AV, 480, active lines.
- V_FP, 10, vertical front porch in lines.
- V_SP, 2, vertical sync pulse in lines.
- V_BP, 33, vertical back porch in lines; must be >= 1.
- H_POL, 0, active level of hSync.
- V_POL, 0, active level of vSync.
- PIPE_DELAY, 0, number of ce-qualified stages on the *D outputs (0..15).
- FC_W, 8, frameCount width.

Ports:
- pixClk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- ce  in  1  pixel advance enable; tie high for one pixel per clock.
- x  out  CW  current column.
- y  out  CW  current line.
- hSync  out  1  stage-0 horizontal sync.
- vSync  out  1  stage-0 vertical sync.
- valid  out  1  stage-0 active-video flag.
- lineStart  out  1  x==0.
- frameStart  out  1  x==0 and y==0.
- frameCount  out  FC_W  frame index.
- hSyncD  out  1  hSync delayed by PIPE_DELAY stages.
- vSyncD  out  1  vSync delayed by PIPE_DELAY stages.
- validD  out  1  valid delayed by PIPE_DELAY stages.
- patR  out  1  test pattern red (see Optional Feature).
- patG  out  1  test pattern green.
- patB  out  1  test pattern blue.

Behaviour:
- Reset and clock:
  - Reset is asynchronous, active-high.
  - Clock is pixClk.
- Derived totals:
  - H_TOTAL = H_AV+H_FP+H_SP+H_BP.
  - V_TOTAL = V_AV+V_FP+V_SP+V_BP.
  - Elaboration error if H_TOTAL > 2^CW, V_TOTAL > 2^CW, H_BP==0 or V_BP==0.
- Reset values:
  - x = H_TOTAL-1, y = V_TOTAL-1 (last pixel of the frame), so the first ce lands on (0,0).
  - frameCount = all ones, so the first frame reads 0.
  - All delay stages hold the inactive level: sync = ~POL, valid = 0.
  - Resulting output values during reset: valid 0; hSync/vSync inactive (inside back porch); lineStart 0; frameStart 0; *D outputs inactive; pat* 0.
- Counting, on pixClk rising edge with ce=1:
  - x increments.
  - If x==H_TOTAL-1: x wraps to 0 and y increments.
  - If x==H_TOTAL-1 and y==V_TOTAL-1: y wraps to 0 and frameCount increments, wrapping modulo 2^FC_W.
  - With ce=0, all state (counters, frameCount, delay line) holds.
- Stage-0 decode, combinational from registered x/y, so always coherent with x/y:
  - hSync = H_POL when H_AV+H_FP <= x < H_AV+H_FP+H_SP, else ~H_POL.
  - vSync is the same form using the V parameters and V_POL.
  - valid = (x<H_AV) & (y<V_AV).
  - lineStart = (x==0).
  - frameStart = (x==0)&(y==0).
  - All comparisons are unsigned, CW bits wide.
- Delay line:
  - {hSync,vSync,valid} shifts one stage per ce.
  - The *D outputs equal stage-0 values exactly PIPE_DELAY ce-pulses earlier.
  - PIPE_DELAY=0 makes the *D outputs combinational copies of stage 0.
- Reset asserted mid-frame immediately forces the reset values (async) and flushes the delay line. No partial sync pulse survives.
- Latency: counters and decode advance one pixel per ce. The *D outputs lag by PIPE_DELAY ce-pulses.

Optional Feature:
- Macro: VGA_TIMING_PATTERN_EN.
- Defined: the block generates 8 vertical colour bars.
  - Bar index = x / (H_AV/8), using an integer divide by a constant.
  - {patR,patG,patB} = 3'b111 - barIndex[2:0] (white first, black last).
  - The pattern is gated by valid and delayed through the same delay line, so it is aligned with validD.
- Undefined: patR/patG/patB are tied to 0 and no pattern logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - localparams for the 640x480@60 defaults;
  - typedef struct packed {logic hSync, vSync, valid; logic [2:0] rgb;} vga_ctl_t;
  - helper function vga_total(av,fp,sp,bp).
- Sub-module vga_delay_line:
  - parametrised DEPTH and element type vga_ctl_t;
  - ce-qualified shift register with async reset to an INIT parameter;
  - DEPTH=0 is a passthrough.

Test Plan:
- Defaults, ce=1, release reset:
  - first edge gives x=0, y=0, frameStart=1, frameCount=0, valid=1;
  - frame period = 420000 clocks;
  - second frameStart gives frameCount=1.
- Defaults:
  - hSync low for x=656..751 (96 clocks per line);
  - vSync low for y=490..491;
  - valid low for x>=640 or y>=480.
- ce toggling 1-0-1-0: x advances once per two clocks, and the line period becomes 1600 clocks.
- PIPE_DELAY=3, H_POL=1:
  - hSyncD rises exactly 3 clocks after hSync rises, at x=659;
  - validD falls at x=643.
- Assert reset at x=700, y=200 (mid-hSync):
  - all syncs return inactive in the same cycle and *D outputs are inactive;
  - after release, the next edge gives (0,0).
- FC_W=2 over 5 frames: frameCount sequence 0,1,2,3,0.
- VGA_TIMING_PATTERN_EN defined: x=0 gives rgb=111, x=80 gives 110, x=560 gives 000, x=640 gives 000 (blank).
